hazard_ctrl: RTL

// Hazard and sequencing controller for the 5-stage RV32I pipeline (F/D/E/M/W).
// - Keeps internal shadow copies of the E/M/W destination-register state.
// - Generates per-stage stall/flush, load-use interlock, branch/jump flush,

---
 rtl/hazard_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline: tracks E/M/W
// destination state and produces stall/flush, forwarding selects and perf counters.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             uses_rs1_d,
    input  logic             uses_rs2_d,
    input  logic [4:0]       rd_d,
    input  logic             reg_write_d,
    input  logic [1:0]       result_src_d,
    input  logic             pc_src_e,
    input  logic             dmem_ready_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [4:0]       e_rd_q, e_rs1_q, e_rs2_q, m_rd_q, w_rd_q;
    logic             e_rw_q, e_ld_q, m_rw_q, w_rw_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic mem_wait, branch, load_use, lu_act;
    logic [1:0] fwd_a, fwd_b;

    always_comb begin
        mem_wait = ~dmem_ready_m;
        branch   = pc_src_e & dmem_ready_m;
        load_use = e_ld_q & e_rw_q &
                   ((uses_rs1_d & (rs1_d == e_rd_q)) | (uses_rs2_d & (rs2_d == e_rd_q)));
        // A resolved branch discards the decode instruction, so its interlock is moot.
        lu_act   = load_use & dmem_ready_m & ~pc_src_e;

        fwd_a = 2'b00;
        if (m_rw_q && (m_rd_q == e_rs1_q))      fwd_a = 2'b10;
        else if (w_rw_q && (w_rd_q == e_rs1_q)) fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (m_rw_q && (m_rd_q == e_rs2_q))      fwd_b = 2'b10;
        else if (w_rw_q && (w_rd_q == e_rs2_q)) fwd_b = 2'b01;

        stall_f     = ~srst & (mem_wait | lu_act);
        stall_d     = ~srst & (mem_wait | lu_act);
        stall_e     = ~srst & mem_wait;
        stall_m     = ~srst & mem_wait;
        flush_d     = srst | branch;
        flush_e     = srst | branch | lu_act;
        flush_w     = srst | mem_wait;
        forward_a_e = srst ? 2'b00 : fwd_a;
        forward_b_e = srst ? 2'b00 : fwd_b;
        stall_cnt   = stall_cnt_q;
        flush_cnt   = flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            e_rd_q      <= '0;
            e_rs1_q     <= '0;
            e_rs2_q     <= '0;
            e_rw_q      <= 1'b0;
            e_ld_q      <= 1'b0;
            m_rd_q      <= '0;
            m_rw_q      <= 1'b0;
            w_rd_q      <= '0;
            w_rw_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (branch && (flush_cnt_q != '1))  flush_cnt_q <= flush_cnt_q + CNT_ONE;

            if (mem_wait) begin
                // E and M hold; the W slot drains as a bubble.
                w_rw_q <= 1'b0;
            end else begin
                w_rd_q <= m_rd_q;
                w_rw_q <= m_rw_q;
                m_rd_q <= e_rd_q;
                m_rw_q <= e_rw_q;
                if (branch || lu_act) begin
                    e_rd_q  <= '0;
                    e_rs1_q <= '0;
                    e_rs2_q <= '0;
                    e_rw_q  <= 1'b0;
                    e_ld_q  <= 1'b0;
                end else begin
                    e_rd_q  <= rd_d;
                    e_rs1_q <= rs1_d;
                    e_rs2_q <= rs2_d;
                    e_rw_q  <= reg_write_d & (rd_d != 5'd0);
                    e_ld_q  <= (result_src_d == 2'b01);
                end
            end
        end
    end

endmodule
